sig_gen: RTL and testbench

//   Programmable square-wave generator: the stimulus source feeding the frequency meter.
//   - Selects one of four preset frequencies (testmode) or a custom half-period.
//   - Produces sigout, divided from sysclk.
//   - Applies frequency changes only at a period boundary, so sigout never glitches.

---
 rtl/sig_gen_pkg.sv | 25 ++
 rtl/sig_gen_setting.sv | 84 ++++++++
 rtl/sig_gen.sv | 110 +++++++++++
 tb/tb_sig_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sig_gen_pkg.sv
// Shared constants for sig_gen: preset half-periods derived from CLK_HZ, FSM states, and a 0->1 clamp.
package sig_gen_pkg;

  localparam int CLK_HZ    = 100_000_000;
  localparam int DIV_W_DEF = 27;

  // Index = testmode: 1 kHz, 10 kHz, 100 kHz, 1 MHz; each entry is half a period in sysclk cycles
  localparam logic [31:0] PRESET_HALF [0:3] = '{
    32'(CLK_HZ / (2 * 1_000)),
    32'(CLK_HZ / (2 * 10_000)),
    32'(CLK_HZ / (2 * 100_000)),
    32'(CLK_HZ / (2 * 1_000_000))
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  function automatic logic [31:0] clamp_half(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/sig_gen_setting.sv
// Pending/active half-period registers with change detect and busy flag; active takes pending on boundary.
// With SIG_GEN_DUTY_EN defined, custom_lo sets the low phase independently; otherwise lo follows hi.
module sig_gen_setting
  import sig_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [1:0]       testmode,
  input  logic             custom_en,
  input  logic [DIV_W-1:0] custom_hi,
  input  logic [DIV_W-1:0] custom_lo,
  input  logic             load,
  input  logic             boundary,
  output logic [DIV_W-1:0] active_hi,
  output logic [DIV_W-1:0] active_lo,
  output logic             busy
);

  logic [DIV_W-1:0] preset_half;
  logic [DIV_W-1:0] new_hi, new_lo;
  logic             update;

  logic [DIV_W-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [DIV_W-1:0] act_hi_q, act_hi_d, act_lo_q, act_lo_d;
  logic             busy_q, busy_d;
  logic [1:0]       testmode_q;
  logic             custom_en_q;

  assign preset_half = DIV_W'(PRESET_HALF[testmode]);

`ifndef SIG_GEN_DUTY_EN
  logic unused_custom_lo;
  assign unused_custom_lo = ^custom_lo;
`endif

  always_comb begin
    new_hi = preset_half;
    new_lo = preset_half;
    if (custom_en) begin
      new_hi = DIV_W'(clamp_half(32'(custom_hi)));
`ifdef SIG_GEN_DUTY_EN
      new_lo = DIV_W'(clamp_half(32'(custom_lo)));
`else
      new_lo = new_hi;
`endif
    end

    update = load || (testmode != testmode_q) || (custom_en != custom_en_q);

    // Active samples the old pending, so an update on the boundary cycle waits one more period
    act_hi_d  = boundary ? pend_hi_q : act_hi_q;
    act_lo_d  = boundary ? pend_lo_q : act_lo_q;
    pend_hi_d = update ? new_hi : pend_hi_q;
    pend_lo_d = update ? new_lo : pend_lo_q;
    busy_d    = update ? 1'b1 : (boundary ? 1'b0 : busy_q);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pend_hi_q   <= preset_half;
      pend_lo_q   <= preset_half;
      act_hi_q    <= preset_half;
      act_lo_q    <= preset_half;
      busy_q      <= 1'b0;
      testmode_q  <= testmode;
      custom_en_q <= 1'b0;
    end else begin
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      act_hi_q    <= act_hi_d;
      act_lo_q    <= act_lo_d;
      busy_q      <= busy_d;
      testmode_q  <= testmode;
      custom_en_q <= custom_en;
    end
  end

  assign active_hi = act_hi_q;
  assign active_lo = act_lo_q;
  assign busy      = busy_q;

endmodule

// File: rtl/sig_gen.sv
// Glitch-free programmable square-wave generator; settings switch only at period boundaries.
// First rising edge 1 cycle after enable; SIG_GEN_DUTY_EN enables independent custom low phase.
module sig_gen
  import sig_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       testmode,
  input  logic             custom_en,
  input  logic [DIV_W-1:0] custom_hi,
  input  logic [DIV_W-1:0] custom_lo,
  input  logic             load,
  output logic             sigout,
  output logic             period_done,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sigout_q, sigout_d;
  logic             period_done_q, period_done_d;
  logic             boundary;
  logic [DIV_W-1:0] active_hi, active_lo;

  sig_gen_setting #(.DIV_W(DIV_W)) u_setting (
    .sysclk    (sysclk),
    .reset     (reset),
    .testmode  (testmode),
    .custom_en (custom_en),
    .custom_hi (custom_hi),
    .custom_lo (custom_lo),
    .load      (load),
    .boundary  (boundary),
    .active_hi (active_hi),
    .active_lo (active_lo),
    .busy      (busy)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sigout_d      = sigout_q;
    period_done_d = 1'b0;
    boundary      = 1'b0;

    case (state_q)
      IDLE: begin
        sigout_d = 1'b0;
        cnt_d    = '0;
        if (enable) begin
          boundary      = 1'b1;
          sigout_d      = 1'b1;
          period_done_d = 1'b1;
          state_d       = HIGH;
        end
      end
      HIGH: begin
        if (cnt_q == active_hi - DIV_W'(1)) begin
          sigout_d = 1'b0;
          cnt_d    = '0;
          state_d  = LOW;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      LOW: begin
        if (cnt_q == active_lo - DIV_W'(1)) begin
          cnt_d = '0;
          if (enable) begin
            boundary      = 1'b1;
            sigout_d      = 1'b1;
            period_done_d = 1'b1;
            state_d       = HIGH;
          end else begin
            sigout_d = 1'b0;
            state_d  = IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        sigout_d = 1'b0;
        cnt_d    = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sigout_q      <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sigout_q      <= sigout_d;
      period_done_q <= period_done_d;
    end
  end

  assign sigout      = sigout_q;
  assign period_done = period_done_q;

endmodule

// File: tb/tb_sig_gen.sv
// Directed bench for sig_gen: table of settings with measured high/low lengths, plus boundary sequences.
module tb_sig_gen;

  localparam int DIV_W = 27;
  localparam int LIMIT = 60000;

  logic             sysclk = 1'b0;
  logic             reset;
  logic             enable;
  logic [1:0]       testmode;
  logic             custom_en;
  logic [DIV_W-1:0] custom_hi;
  logic [DIV_W-1:0] custom_lo;
  logic             load;
  logic             sigout;
  logic             period_done;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  always #5 sysclk = ~sysclk;

  sig_gen #(.DIV_W(DIV_W)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .enable      (enable),
    .testmode    (testmode),
    .custom_en   (custom_en),
    .custom_hi   (custom_hi),
    .custom_lo   (custom_lo),
    .load        (load),
    .sigout      (sigout),
    .period_done (period_done),
    .busy        (busy)
  );

  typedef struct {
    logic [1:0] tm;
    logic       cen;
    int         hi;
    int         lo;
    int         exp_hi;
    int         exp_lo;
    string      name;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge sysclk);
  endtask

  // Counts sampled cycles while sigout holds lvl; stops at LIMIT so a stuck output cannot hang the run
  task automatic count_level(input logic lvl, output int n, output int pd);
    n  = 0;
    pd = 0;
    while (sigout == lvl && n < LIMIT) begin
      if (period_done) pd++;
      n++;
      @(negedge sysclk);
    end
  endtask

  task automatic wait_rise(input string name);
    int n, pd;
    if (sigout) count_level(1'b1, n, pd);
    count_level(1'b0, n, pd);
    check({name, "_rise_seen"}, int'(sigout), 1);
  endtask

  task automatic measure(output int hi, output int lo, output int pd);
    int pd_h, pd_l;
    count_level(1'b1, hi, pd_h);
    count_level(1'b0, lo, pd_l);
    pd = pd_h + pd_l;
  endtask

  initial begin
    int hi, lo, pd, n, guard, highs;

    vecs[0] = '{2'b10, 1'b0, 0, 0, 500, 500, "preset10"};
    vecs[1] = '{2'b11, 1'b0, 0, 0, 50, 50, "preset11"};
`ifdef SIG_GEN_DUTY_EN
    vecs[2] = '{2'b11, 1'b1, 0, 5, 1, 5, "custom_hi0"};
    vecs[3] = '{2'b11, 1'b1, 3, 7, 3, 7, "custom_3_7"};
    vecs[4] = '{2'b11, 1'b1, 6, 0, 6, 1, "custom_lo0"};
`else
    vecs[2] = '{2'b11, 1'b1, 0, 5, 1, 1, "custom_hi0"};
    vecs[3] = '{2'b11, 1'b1, 3, 7, 3, 3, "custom_3_7"};
    vecs[4] = '{2'b11, 1'b1, 6, 0, 6, 6, "custom_lo0"};
`endif
    vecs[5] = '{2'b01, 1'b0, 0, 0, 5000, 5000, "preset01"};

    reset = 1'b1; enable = 1'b0; load = 1'b0; custom_en = 1'b0;
    testmode = 2'b00; custom_hi = '0; custom_lo = '0;
    step(2);
    check("reset_sigout", int'(sigout), 0);
    check("reset_period_done", int'(period_done), 0);
    check("reset_busy", int'(busy), 0);

    reset = 1'b0;
    step(3);
    check("idle_sigout", int'(sigout), 0);
    enable = 1'b1;
    step(1);
    check("first_rise_sigout", int'(sigout), 1);
    check("first_rise_pd", int'(period_done), 1);
    step(1);
    check("pd_single_cycle", int'(period_done), 0);
    step(2000);
    check("preset00_still_high", int'(sigout), 1);
    check("preset00_busy", int'(busy), 0);

    // Table: reprogram a running generator, let the change take effect, then measure one whole period
    reset = 1'b1; enable = 1'b0; testmode = 2'b11;
    step(2);
    reset = 1'b0; enable = 1'b1;
    for (int v = 0; v < 6; v++) begin
      testmode  = vecs[v].tm;
      custom_en = vecs[v].cen;
      custom_hi = DIV_W'(vecs[v].hi);
      custom_lo = DIV_W'(vecs[v].lo);
      load      = vecs[v].cen;
      step(1);
      load = 1'b0;
      guard = 0;
      while (busy && guard < LIMIT) begin
        step(1);
        guard++;
      end
      check({vecs[v].name, "_busy_clear"}, int'(busy), 0);
      wait_rise(vecs[v].name);
      measure(hi, lo, pd);
      check({vecs[v].name, "_hi"}, hi, vecs[v].exp_hi);
      check({vecs[v].name, "_lo"}, lo, vecs[v].exp_lo);
      check({vecs[v].name, "_pd_count"}, pd, 1);
    end

    // testmode 11 -> 01 mid-HIGH: old 100-cycle period finishes, then a 5000-cycle high phase
    reset = 1'b1; enable = 1'b0; testmode = 2'b11; custom_en = 1'b0;
    step(2);
    reset = 1'b0; enable = 1'b1;
    wait_rise("tm_switch");
    step(10);
    testmode = 2'b01;
    step(2);
    check("tm_switch_busy_set", int'(busy), 1);
    count_level(1'b1, n, pd);
    check("tm_switch_old_high_rest", n, 38);
    check("tm_switch_busy_in_low", int'(busy), 1);
    count_level(1'b0, n, pd);
    check("tm_switch_old_low", n, 50);
    check("tm_switch_busy_cleared", int'(busy), 0);
    check("tm_switch_pd_at_rise", int'(period_done), 1);
    count_level(1'b1, n, pd);
    check("tm_switch_new_high", n, 5000);

    // enable dropped at cnt=10 of HIGH: period completes, output parks low, restart is 1 cycle
    reset = 1'b1; enable = 1'b0; testmode = 2'b11;
    step(2);
    reset = 1'b0; enable = 1'b1;
    wait_rise("stop");
    step(10);
    enable = 1'b0;
    count_level(1'b1, n, pd);
    check("stop_high_rest", n, 40);
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      if (sigout) highs++;
      step(1);
    end
    check("stop_stays_low", highs, 0);
    enable = 1'b1;
    step(1);
    check("restart_sigout", int'(sigout), 1);
    check("restart_pd", int'(period_done), 1);

    // Load on the boundary cycle: old 4/4 period runs once more, new 2/2 follows
    reset = 1'b1; enable = 1'b0; custom_en = 1'b1; custom_hi = DIV_W'(4); custom_lo = DIV_W'(4);
    step(2);
    reset = 1'b0; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    enable = 1'b1;
    wait_rise("bnd");
    step(7);
    check("bnd_last_low", int'(sigout), 0);
    custom_hi = DIV_W'(2); custom_lo = DIV_W'(2); load = 1'b1;
    step(1);
    load = 1'b0;
    check("bnd_rise", int'(sigout), 1);
    check("bnd_busy_held", int'(busy), 1);
    measure(hi, lo, pd);
    check("bnd_old_hi", hi, 4);
    check("bnd_old_lo", lo, 4);
    check("bnd_busy_cleared", int'(busy), 0);
    measure(hi, lo, pd);
    check("bnd_new_hi", hi, 2);
    check("bnd_new_lo", lo, 2);

    // Reset between clock edges: mid-LOW with a pending load, then mid-HIGH
    step(2);
    check("rst_low_phase", int'(sigout), 0);
    custom_hi = DIV_W'(9); load = 1'b1;
    step(1);
    load = 1'b0;
    check("rst_busy_before", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_low_sigout", int'(sigout), 0);
    check("rst_low_busy", int'(busy), 0);
    step(1);
    reset = 1'b0; custom_en = 1'b0; testmode = 2'b11;
    step(2);
    wait_rise("rst_high");
    step(1);
    check("rst_high_before", int'(sigout), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_high_sigout", int'(sigout), 0);
    check("rst_high_pd", int'(period_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
